// File: rtl/pwm_ramp_sequencer.sv
// AXI4-Lite write master: programs PERIOD/DUTY/CTRL, steps DUTY once per irq tick, then disables.
// One write in flight at a time; each VALID holds until its READY, BREADY waits for BVALID.
module pwm_ramp_sequencer #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR   = 4'h0,
    parameter logic [ADDR_WIDTH-1:0] PERIOD_ADDR = 4'h4,
    parameter logic [ADDR_WIDTH-1:0] DUTY_ADDR   = 4'h8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             cfg_period,
    input  logic [31:0]             cfg_duty_start,
    input  logic [31:0]             cfg_duty_end,
    input  logic [31:0]             cfg_duty_step,
    input  logic                    irq,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             cur_duty
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PERIOD,
        S_WR_DUTY,
        S_WR_CTRL,
        S_WAIT_TICK,
        S_WR_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [31:0]             cur_duty_q, cur_duty_d;
    logic [31:0]             period_q, period_d;
    logic [31:0]             duty_start_q, duty_start_d;
    logic [31:0]             duty_end_q, duty_end_d;
    logic [31:0]             step_q, step_d;
    logic                    abort_pend_q, abort_pend_d;
    logic                    ctrl_en_q, ctrl_en_d;
    logic                    irq_q;

    logic                    launch;
    state_t                  launch_state;
    logic [ADDR_WIDTH-1:0]   launch_addr;
    logic [31:0]             launch_data;
    logic                    aw_ok;
    logic                    w_ok;
    logic                    tick;
    logic [32:0]             duty_sum;
    logic [31:0]             duty_next;
    logic                    stop_req;

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        cur_duty_d   = cur_duty_q;
        period_d     = period_q;
        duty_start_d = duty_start_q;
        duty_end_d   = duty_end_q;
        step_d       = step_q;
        abort_pend_d = abort_pend_q;
        ctrl_en_d    = ctrl_en_q;
        launch       = 1'b0;
        launch_state = S_IDLE;
        launch_addr  = '0;
        launch_data  = 32'd0;

        aw_ok     = ~awvalid_q | M_AXI_AWREADY;
        w_ok      = ~wvalid_q | M_AXI_WREADY;
        tick      = irq & ~irq_q;
        stop_req  = abort_pend_q | abort;
        // 33-bit sum so a step near the top of the range saturates instead of wrapping
        duty_sum  = {1'b0, cur_duty_q} + {1'b0, step_q};
        duty_next = (duty_sum > {1'b0, duty_end_q}) ? duty_end_q : duty_sum[31:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_duty_step == 32'd0 || cfg_duty_start > cfg_duty_end) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d        = 1'b0;
                        busy_d       = 1'b1;
                        abort_pend_d = 1'b0;
                        ctrl_en_d    = 1'b0;
                        period_d     = cfg_period;
                        duty_start_d = cfg_duty_start;
                        duty_end_d   = cfg_duty_end;
                        step_d       = cfg_duty_step;
                        launch       = 1'b1;
                        launch_state = S_WR_PERIOD;
                        launch_addr  = PERIOD_ADDR;
                        launch_data  = cfg_period;
                    end
                end
            end
            S_WAIT_TICK: begin
                if (abort || (tick && cur_duty_q == duty_end_q)) begin
                    launch       = 1'b1;
                    launch_state = S_WR_STOP;
                    launch_addr  = CTRL_ADDR;
                end else if (tick) begin
                    launch       = 1'b1;
                    launch_state = S_WR_DUTY;
                    launch_addr  = DUTY_ADDR;
                    launch_data  = duty_next;
                end
            end
            default: begin
                if (abort && state_q != S_WR_STOP) abort_pend_d = 1'b1;
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
                if (!bready_q && aw_ok && w_ok) bready_d = 1'b1;

                if (bready_q && M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d = 1'b1;
                        if (state_q == S_WR_STOP) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            launch       = 1'b1;
                            launch_state = S_WR_STOP;
                            launch_addr  = CTRL_ADDR;
                        end
                    end else begin
                        case (state_q)
                            S_WR_PERIOD: begin
                                launch       = 1'b1;
                                launch_state = stop_req ? S_WR_STOP : S_WR_DUTY;
                                launch_addr  = stop_req ? CTRL_ADDR : DUTY_ADDR;
                                launch_data  = stop_req ? 32'd0 : duty_start_q;
                            end
                            S_WR_DUTY: begin
                                cur_duty_d = wdata_q[31:0];
                                if (stop_req) begin
                                    launch       = 1'b1;
                                    launch_state = S_WR_STOP;
                                    launch_addr  = CTRL_ADDR;
                                end else if (ctrl_en_q) begin
                                    state_d = S_WAIT_TICK;
                                end else begin
                                    launch       = 1'b1;
                                    launch_state = S_WR_CTRL;
                                    launch_addr  = CTRL_ADDR;
                                    launch_data  = 32'h3;
                                end
                            end
                            S_WR_CTRL: begin
                                ctrl_en_d = 1'b1;
                                if (stop_req) begin
                                    launch       = 1'b1;
                                    launch_state = S_WR_STOP;
                                    launch_addr  = CTRL_ADDR;
                                end else begin
                                    state_d = S_WAIT_TICK;
                                end
                            end
                            default: begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase

        if (launch) begin
            state_d   = launch_state;
            awaddr_d  = launch_addr;
            wdata_d   = DATA_WIDTH'(launch_data);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cur_duty_q   <= 32'd0;
            period_q     <= 32'd0;
            duty_start_q <= 32'd0;
            duty_end_q   <= 32'd0;
            step_q       <= 32'd0;
            abort_pend_q <= 1'b0;
            ctrl_en_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cur_duty_q   <= cur_duty_d;
            period_q     <= period_d;
            duty_start_q <= duty_start_d;
            duty_end_q   <= duty_end_d;
            step_q       <= step_d;
            abort_pend_q <= abort_pend_d;
            ctrl_en_q    <= ctrl_en_d;
            irq_q        <= irq;
        end
    end

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cur_duty      = cur_duty_q;

endmodule
